key_debounce: RTL and testbench



---
 rtl/key_pkg.sv | 19 +
 rtl/key_debounce_if.sv | 16 +
 rtl/key_debounce_chan.sv | 81 ++++++++
 rtl/key_debounce.sv | 36 +++
 tb/tb_key_debounce.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Purpose : shared constants and helpers for the pushbutton debouncer.
// Latency : n/a (package only).
// Backpressure: n/a; optional build macro KEY_DEBOUNCE_BYPASS_EN is consumed in key_debounce_chan.
package key_pkg;

  // Pushbuttons are active-low, so the idle/released level is 1.
  localparam logic KEY_RELEASED = 1'b1;

  localparam int CLK_FREQ_HZ = 50_000_000;

  // 10 ms of stable level at the system clock rate.
  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * 10;

  // Minimum counter width able to hold DEBOUNCE_CYCLES-1.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Purpose : key bundle between the raw pushbutton pins and the debouncer outputs.
// Latency : n/a (wires only).
// Backpressure: none; levels and pulses only.
// Signals : key_raw (pins, active-low), key_db (debounced level), key_press (press pulse).
interface key_debounce_if #(
  parameter int NUM_KEYS = 2
);
  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_db;
  logic [NUM_KEYS-1:0] key_press;

  // master: drives the pins and observes results.
  modport master (output key_raw, input key_db, input key_press);
  // slave: the debouncer itself.
  modport slave  (input key_raw, output key_db, output key_press);
endinterface

// File: rtl/key_debounce_chan.sv
// Purpose : one key channel: 2-flop synchroniser, stability counter, level flop, press pulse.
// Latency : key_db follows a held raw change DEBOUNCE_CYCLES+1 edges after it first lands in sync1
//           (2 edges total when KEY_DEBOUNCE_BYPASS_EN is defined); key_press is one cycle wide.
// Backpressure: none; free-running. Ports: clk, reset_n, key_raw, key_db, key_press.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = cnt_width(DEFAULT_DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_db,
  output logic key_press
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("key_debounce_chan: DEBOUNCE_CYCLES must be >= 2");
  end
  if ((longint'(1) << CNT_W) < longint'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("key_debounce_chan: CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  logic sync1;
  logic sync2;

`ifdef KEY_DEBOUNCE_BYPASS_EN

  // Filtering removed: the synchronised level is the debounced level.
  assign key_db = sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= KEY_RELEASED;
      sync2     <= KEY_RELEASED;
      key_press <= 1'b0;
    end else begin
      sync1     <= key_raw;
      sync2     <= sync1;
      // sync2 takes sync1 at this edge, so a 1->0 on key_db happens now.
      key_press <= sync2 & ~sync1;
    end
  end

`else

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_db_q;
  logic [CNT_W-1:0] cnt;

  assign key_db = key_db_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= KEY_RELEASED;
      sync2     <= KEY_RELEASED;
      key_db_q  <= KEY_RELEASED;
      cnt       <= '0;
      key_press <= 1'b0;
    end else begin
      sync1     <= key_raw;
      sync2     <= sync1;
      key_press <= 1'b0;
      if (sync2 == key_db_q) begin
        // Level agrees (or a glitch ended): any partial window is discarded.
        cnt <= '0;
      end else if (cnt == CNT_TERM) begin
        key_db_q  <= sync2;
        cnt       <= '0;
        key_press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/key_debounce.sv
// Purpose : debounce NUM_KEYS active-low pushbuttons feeding the key PIO; build option KEY_DEBOUNCE_BYPASS_EN.
// Latency : DEBOUNCE_CYCLES+1 edges from first sync1 sample to key_db (2 edges in bypass build).
// Backpressure: none. Ports: clk, reset_n, kif (key_raw in, key_db / key_press out).
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = cnt_width(DEFAULT_DEBOUNCE_CYCLES)
) (
  input  logic           clk,
  input  logic           reset_n,
  key_debounce_if.slave  kif
);

  logic [NUM_KEYS-1:0] db_w;
  logic [NUM_KEYS-1:0] press_w;

  // Channels are fully independent; no shared state between keys.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .key_raw   (kif.key_raw[i]),
      .key_db    (db_w[i]),
      .key_press (press_w[i])
    );
  end

  assign kif.key_db    = db_w;
  assign kif.key_press = press_w;

endmodule

// File: tb/tb_key_debounce.sv
// Purpose : self-checking bench for key_debounce with DEBOUNCE_CYCLES=4, CNT_W=2.
// Latency : expects key_db to move 5 edges after a raw level is first sampled.
// Backpressure: n/a. Expected per-edge outputs are queued with the stimulus and popped at each negedge.
module tb_key_debounce;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  key_debounce_if #(.NUM_KEYS(2)) kif ();

  key_debounce #(
    .NUM_KEYS        (2),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kif     (kif)
  );

  typedef struct {
    int         cyc;
    logic [1:0] db;
    logic [1:0] press;
  } exp_t;

  exp_t sb_q[$];
  int   edge_no = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue the expected outputs for every edge in [from, to].
  task automatic expect_span(input int from, input int to, input logic [1:0] db, input logic [1:0] press);
    for (int c = from; c <= to; c++) begin
      exp_t e;
      e.cyc   = c;
      e.db    = db;
      e.press = press;
      sb_q.push_back(e);
    end
  endtask

  task automatic score();
    while (sb_q.size() > 0 && sb_q[0].cyc <= edge_no) begin
      exp_t e;
      e = sb_q.pop_front();
      check_val($sformatf("edge%0d_order", edge_no), e.cyc, edge_no);
      check_val($sformatf("edge%0d_db", edge_no), {30'd0, kif.key_db}, {30'd0, e.db});
      check_val($sformatf("edge%0d_press", edge_no), {30'd0, kif.key_press}, {30'd0, e.press});
    end
  endtask

  // Hold raw for n edges; compare outputs half a cycle after each edge.
  task automatic drive(input logic [1:0] raw, input int n);
    for (int i = 0; i < n; i++) begin
      kif.key_raw = raw;
      @(posedge clk);
      edge_no++;
      @(negedge clk);
      score();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    kif.key_raw = 2'b11;
    reset_n     = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_db", {30'd0, kif.key_db}, 32'h3);
    check_val("rst_press", {30'd0, kif.key_press}, 32'h0);
    reset_n = 1'b1;
    edge_no = 0;

    // Idle after reset: no spurious pulse.
    expect_span(1, 20, 2'b11, 2'b00);
    drive(2'b11, 20);

    // Key 0 press sampled at edge 21 -> falls at 26, one-cycle pulse.
    expect_span(21, 25, 2'b11, 2'b00);
    expect_span(26, 26, 2'b10, 2'b01);
    expect_span(27, 32, 2'b10, 2'b00);
    drive(2'b10, 12);

    // Key 1 glitch of 3 cycles is rejected.
    expect_span(33, 45, 2'b10, 2'b00);
    drive(2'b00, 3);
    drive(2'b10, 10);

    // Key 1 held low: sampled at 46, falls at 51.
    expect_span(46, 50, 2'b10, 2'b00);
    expect_span(51, 51, 2'b00, 2'b10);
    expect_span(52, 55, 2'b00, 2'b00);
    drive(2'b00, 10);

    // Key 0 released: rises at 61, no pulse on release.
    expect_span(56, 60, 2'b00, 2'b00);
    expect_span(61, 67, 2'b01, 2'b00);
    drive(2'b01, 12);

    // Key 1 released too.
    expect_span(68, 72, 2'b01, 2'b00);
    expect_span(73, 79, 2'b11, 2'b00);
    drive(2'b11, 12);

    // Both pressed together: same-edge fall and pulses.
    expect_span(80, 84, 2'b11, 2'b00);
    expect_span(85, 85, 2'b00, 2'b11);
    expect_span(86, 91, 2'b00, 2'b00);
    drive(2'b00, 12);

    expect_span(92, 96, 2'b00, 2'b00);
    expect_span(97, 103, 2'b11, 2'b00);
    drive(2'b11, 12);

    // Key 0 low long enough for cnt to reach 2, then reset mid-count.
    expect_span(104, 107, 2'b11, 2'b00);
    drive(2'b10, 4);
    reset_n = 1'b0;
    #1;
    check_val("midrst_db", {30'd0, kif.key_db}, 32'h3);
    check_val("midrst_press", {30'd0, kif.key_press}, 32'h0);
    repeat (3) @(negedge clk);
    check_val("midrst_hold_db", {30'd0, kif.key_db}, 32'h3);
    check_val("midrst_hold_press", {30'd0, kif.key_press}, 32'h0);
    reset_n = 1'b1;
    edge_no = 200;

    // Fresh window after reset: first sample at 201, fall at 206.
    expect_span(201, 205, 2'b11, 2'b00);
    expect_span(206, 206, 2'b10, 2'b01);
    expect_span(207, 210, 2'b10, 2'b00);
    drive(2'b10, 10);

    check_val("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
